// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/halt sequencer for the 5-stage pipeline: PC and pipeline-register enables and flushes.
// Optional STALL_CNT_EN adds saturating load-use, memory-stall and branch-flush event counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] idRs,
  input  logic [2:0] idRt,
  input  logic       idUsesRs,
  input  logic       idUsesRt,
  input  logic       exMemRead,
  input  logic       exRegWrite,
  input  logic [2:0] exRd,
  input  logic       branchTaken,
  input  logic       memReq,
  input  logic       memStall,
  input  logic       wbHalt,
  output logic       pcEn,
  output logic       ifidEn,
  output logic       ifidFlush,
  output logic       idexEn,
  output logic       idexFlush,
  output logic       exmemEn,
  output logic       memwbEn,
  output logic       memwbFlush,
  output logic       halted,
  output logic       err
`ifdef STALL_CNT_EN
  ,
  output logic [15:0] luCnt,
  output logic [15:0] memStallCnt,
  output logic [15:0] flushCnt
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   waitCnt, waitCntNext;
  logic               errReg, errNext;
  logic               luHaz, memHold;
  logic               runRules, freeze;
  logic               ruleBranch, ruleLu, ruleFlow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      waitCnt <= '0;
      errReg  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      errReg  <= errNext;
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    errNext     = errReg;
    runRules    = 1'b0;
    freeze      = 1'b0;
    ruleBranch  = 1'b0;
    ruleLu      = 1'b0;
    ruleFlow    = 1'b0;
    pcEn        = 1'b0;
    ifidEn      = 1'b0;
    ifidFlush   = 1'b0;
    idexEn      = 1'b0;
    idexFlush   = 1'b0;
    exmemEn     = 1'b0;
    memwbEn     = 1'b0;
    memwbFlush  = 1'b0;

    luHaz   = exMemRead & exRegWrite &
              ((idUsesRs & (idRs == exRd)) | (idUsesRt & (idRt == exRd)));
    memHold = memReq & memStall;

    case (state)
      RUN: begin
        if (wbHalt) begin
          stateNext = HALTED;
        end else if (memHold) begin
          freeze      = 1'b1;
          stateNext   = MEM_WAIT;
          waitCntNext = CNT_W'(1);
        end else begin
          runRules = 1'b1;
        end
      end
      MEM_WAIT: begin
        // EX/ID stay frozen here, so branch and load-use are simply re-seen in RUN
        if (!memStall) begin
          runRules    = 1'b1;
          stateNext   = RUN;
          waitCntNext = '0;
        end else begin
          freeze = 1'b1;
          if (waitCnt == CNT_W'(MEM_TIMEOUT)) begin
            stateNext = HALTED;
            errNext   = 1'b1;
          end else begin
            waitCntNext = waitCnt + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (runRules) begin
      if (branchTaken)  ruleBranch = 1'b1;
      else if (luHaz)   ruleLu     = 1'b1;
      else              ruleFlow   = 1'b1;
    end

    if (freeze) begin
      memwbEn    = 1'b1;
      memwbFlush = 1'b1;
    end
    if (ruleBranch || ruleFlow) begin
      pcEn    = 1'b1;
      ifidEn  = 1'b1;
      idexEn  = 1'b1;
      exmemEn = 1'b1;
      memwbEn = 1'b1;
    end
    if (ruleBranch) begin
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end
    if (ruleLu) begin
      idexEn    = 1'b1;
      idexFlush = 1'b1;
      exmemEn   = 1'b1;
      memwbEn   = 1'b1;
    end

    halted = (state == HALTED);
    err    = errReg;

    if (rst) begin
      pcEn       = 1'b0;
      ifidEn     = 1'b0;
      ifidFlush  = 1'b0;
      idexEn     = 1'b0;
      idexFlush  = 1'b0;
      exmemEn    = 1'b0;
      memwbEn    = 1'b0;
      memwbFlush = 1'b0;
      halted     = 1'b0;
      err        = 1'b0;
    end
  end

`ifdef STALL_CNT_EN
  // freeze covers both the memHold entry cycle and every stalled MEM_WAIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      luCnt       <= '0;
      memStallCnt <= '0;
      flushCnt    <= '0;
    end else begin
      if (ruleLu && luCnt != 16'hFFFF)             luCnt       <= luCnt + 16'd1;
      if (freeze && memStallCnt != 16'hFFFF)       memStallCnt <= memStallCnt + 16'd1;
      if (ruleBranch && flushCnt != 16'hFFFF)      flushCnt    <= flushCnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage 16-bit pipeline.
- Drives the load-enable and flush (bubble-insert) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three conditions: load-use hazards, taken-branch squash, and multi-cycle data-memory stalls.
- Owns the halt/error state: freezes the machine on a HALT in WB or on a memory timeout.

Parameters:
- CNT_W, 4, width of the memory-wait counter.
- MEM_TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before error. Must be ≤ 2^CNT_W−1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- idRs  input  3  source register A of the instruction in ID.
- idRt  input  3  source register B of the instruction in ID.
- idUsesRs  input  1  ID instruction reads idRs.
- idUsesRt  input  1  ID instruction reads idRt.
- exMemRead  input  1  EX instruction is a load.
- exRegWrite  input  1  EX instruction writes a register.
- exRd  input  3  destination register of the EX instruction.
- branchTaken  input  1  EX resolved a taken branch or jump.
- memReq  input  1  MEM stage is issuing a data-memory access.
- memStall  input  1  data memory is not ready this cycle.
- wbHalt  input  1  HALT instruction is in WB.
- pcEn  output  1  PC load enable.
- ifidEn  output  1  IF/ID load enable.
- ifidFlush  output  1  IF/ID loads a NOP.
- idexEn  output  1  ID/EX load enable.
- idexFlush  output  1  ID/EX loads a NOP.
- exmemEn  output  1  EX/MEM load enable.
- memwbEn  output  1  MEM/WB load enable.
- memwbFlush  output  1  MEM/WB loads a NOP (regWrite=0).
- halted  output  1  machine stopped (HALT or error).
- err  output  1  memory-timeout error.

Behaviour:
- Reset and state register:
  - Clock is clk. Reset rst is synchronous and active-high.
  - States: RUN, MEM_WAIT, HALTED. Reset state is RUN; wait counter is reset to 0; err is reset to 0.
  - While rst=1: all enables 0, all flushes 0, halted=0, err=0.
- Output decode:
  - All control outputs are combinational from state and inputs; there is no extra latency.
  - halted and err are decoded from registered state only.
- Load-use hazard, luHaz:
  - luHaz = exMemRead & exRegWrite & ((idUsesRs & idRs==exRd) | (idUsesRt & idRt==exRd)).
  - Register 0 is not special.
- memHold = memReq & memStall.
- RUN priority, highest first:
  1. wbHalt: memwbEn=0, all other enables 0; next state HALTED. The HALT instruction itself has already written back.
  2. memHold: pcEn=ifidEn=idexEn=exmemEn=0, memwbEn=1, memwbFlush=1; next state MEM_WAIT; counter←1.
  3. branchTaken: all enables 1, ifidFlush=1, idexFlush=1. This squashes the 2 younger instructions, including any luHaz victim, so luHaz is ignored.
  4. luHaz: pcEn=0, ifidEn=0, idexEn=1, idexFlush=1, exmemEn=1, memwbEn=1. This gives a 1-cycle stall.
  5. Otherwise: all enables 1, all flushes 0.
- MEM_WAIT:
  - Same freeze outputs as memHold.
  - branchTaken and luHaz are ignored; they persist because EX/ID are frozen and are re-evaluated in RUN.
  - memStall=0: complete the access this cycle with RUN-style outputs (rules 3–5 apply); next state RUN; counter←0.
  - memStall=1 and counter==MEM_TIMEOUT: next state HALTED; err←1.
  - Otherwise: counter←counter+1.
  - wbHalt cannot be asserted in MEM_WAIT because MEM/WB holds a bubble; it is ignored.
- HALTED:
  - All enables 0, flushes 0, halted=1.
  - Left only via rst.
- Counter never wraps: the timeout check precedes increment.
- Simultaneous flush and enable: when a stage's flush=1, its enable is also 1.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined: adds outputs luCnt[15:0], memStallCnt[15:0], flushCnt[15:0].
  - luCnt increments on each cycle rule 4 applies.
  - memStallCnt increments on each cycle in MEM_WAIT or on a memHold entry.
  - flushCnt increments on each cycle rule 3 applies.
  - All three saturate at 16'hFFFF, reset to 0 on rst, and do not count in HALTED.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Load-use: exMemRead=1, exRegWrite=1, exRd=3, idRs=3, idUsesRs=1 for 1 cycle → pcEn=0, ifidEn=0, idexFlush=1 that cycle. Next cycle with exMemRead=0 → all enables 1.
- Branch vs. load-use: branchTaken=1 with luHaz=1 → pcEn=1, ifidFlush=1, idexFlush=1, no stall.
- Memory stall: memReq=1, memStall=1 for 3 cycles, then 0 → 3 cycles of pcEn=exmemEn=0 and memwbFlush=1. 4th cycle all enables 1, state RUN. With STALL_CNT_EN, memStallCnt=3.
- Timeout: MEM_TIMEOUT=4, memReq=memStall=1 held → after 5 frozen cycles halted=1, err=1. Outputs stay frozen until rst. After rst, err=0 and state is RUN.
- HALT: wbHalt=1 → next cycle halted=1, err=0, all enables 0. branchTaken=1 afterwards has no effect.
- Reset mid-stall: rst=1 during MEM_WAIT → next cycle RUN, counter 0, outputs normal with memStall=0.
